mfp_uart_rx_sampler: RTL

//  16x-oversampled UART receiver (8N1, LSB first) that sits directly upstream of the SREC parser in the serial loader path.

---
 rtl/mfp_uart_rx_sampler_pkg.sv | 25 ++
 rtl/mfp_uart_baud_tick.sv | 32 +++
 rtl/mfp_uart_rx_sampler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mfp_uart_rx_sampler_pkg.sv
// Shared constants, FSM encoding and vote helper for the UART RX sampler.
package mfp_uart_rx_sampler_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_LO  = 7;
  localparam int unsigned SAMPLE_MID = 8;
  localparam int unsigned SAMPLE_HI  = 9;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned SC_W       = 4;
  localparam int unsigned IDX_W      = 3;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Two-out-of-three vote across the mid-bit samples.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mfp_uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIVISOR clocks, phase reset by clear.
module mfp_uart_baud_tick #(
  parameter int unsigned DIVISOR = 10
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(DIVISOR);

  logic [CNT_W-1:0] cnt;

  // Divide-by-DIVISOR counter; clear realigns phase to the detected start edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_W'(DIVISOR - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/mfp_uart_rx_sampler.sv
// 16x-oversampled 8N1 UART receiver with majority vote, false-start rejection,
// framing-error strobe and break handling; feeds the SREC parser byte stream.
module mfp_uart_rx_sampler
  import mfp_uart_rx_sampler_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       frame_error,
  output logic       rx_busy
);

  localparam int unsigned DIVISOR =
    (CLK_FREQ + BAUD_RATE * (OVERSAMPLE / 2)) / (BAUD_RATE * OVERSAMPLE);

  rx_state_e         state, state_nxt;
  logic              rx_meta, rx_sync, rx_prev;
  logic              fall_c, tick, clear_c;
  logic [SC_W-1:0]   sc;
  logic [IDX_W-1:0]  idx;
  logic              s_lo, s_mid, vote_c;
  logic              bit_valid, bit_val;
  logic [7:0]        shreg;
  logic              at_lo_c, at_mid_c, at_hi_c, at_end_c;
  logic              shift_c, byte_ready_c, frame_error_c, busy_c;

  assign fall_c   = rx_prev & ~rx_sync;
  assign clear_c  = (state == RX_IDLE) & fall_c;
  assign at_lo_c  = tick & (sc == SC_W'(SAMPLE_LO));
  assign at_mid_c = tick & (sc == SC_W'(SAMPLE_MID));
  assign at_hi_c  = tick & (sc == SC_W'(SAMPLE_HI));
  assign at_end_c = tick & (sc == SC_W'(OVERSAMPLE - 1));
  assign vote_c   = majority3(s_lo, s_mid, rx_sync);

  mfp_uart_baud_tick #(.DIVISOR(DIVISOR)) u_baud_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear_c),
    .tick    (tick)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= RX_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:      if (fall_c) state_nxt = RX_START;
      RX_START:     if (at_hi_c) state_nxt = vote_c ? RX_IDLE : RX_DATA;
      RX_DATA:      if (at_end_c && bit_valid && idx == IDX_W'(DATA_BITS - 1))
                      state_nxt = RX_STOP;
      RX_STOP:      if (at_hi_c) state_nxt = vote_c ? RX_IDLE : RX_WAIT_IDLE;
      RX_WAIT_IDLE: if (at_end_c && rx_sync) state_nxt = RX_IDLE;
      default:      state_nxt = RX_IDLE;
    endcase
  end

  // Output/control decode; strobes and busy are registered below.
  always_comb begin
    shift_c       = 1'b0;
    byte_ready_c  = 1'b0;
    frame_error_c = 1'b0;
    busy_c        = (state_nxt == RX_DATA) || (state_nxt == RX_STOP);
    if (state == RX_DATA && at_end_c && bit_valid) shift_c = 1'b1;
    if (state == RX_STOP && at_hi_c) begin
      byte_ready_c  = vote_c;
      frame_error_c = ~vote_c;
    end
  end

  // Synchronizer, mid-bit samples, sample/bit counters and shift register.
  // The first count-15 after START->DATA is still the start bit, so a shift
  // only happens once a vote has been taken inside DATA (bit_valid).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      s_lo      <= 1'b1;
      s_mid     <= 1'b1;
      bit_valid <= 1'b0;
      bit_val   <= 1'b0;
      idx       <= '0;
      sc        <= '0;
      shreg     <= '0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (at_lo_c)  s_lo  <= rx_sync;
      if (at_mid_c) s_mid <= rx_sync;
      if (at_hi_c)  bit_val <= vote_c;

      if (state != RX_DATA)  bit_valid <= 1'b0;
      else if (at_hi_c)      bit_valid <= 1'b1;
      else if (shift_c)      bit_valid <= 1'b0;

      if (state != RX_DATA) idx <= '0;
      else if (shift_c)     idx <= (idx == IDX_W'(DATA_BITS - 1)) ? '0 : idx + IDX_W'(1);

      if (shift_c) shreg <= {bit_val, shreg[7:1]};

      if (state == RX_IDLE || (state == RX_STOP && state_nxt == RX_WAIT_IDLE))
        sc <= '0;
      else if (tick) begin
        if (state == RX_WAIT_IDLE && !rx_sync)   sc <= '0;
        else if (sc == SC_W'(OVERSAMPLE - 1))    sc <= '0;
        else                                     sc <= sc + SC_W'(1);
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      byte_data   <= '0;
      byte_ready  <= 1'b0;
      frame_error <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      if (byte_ready_c) byte_data <= shreg;
      byte_ready  <= byte_ready_c;
      frame_error <= frame_error_c;
      rx_busy     <= busy_c;
    end
  end

endmodule
